// File: rtl/steer_en.sv
// -----------------------------------------------------------------------------
// steer_en
//
// Rider-detect and steering-enable controller. It sits in front of
// balance_cntrl and produces that block's rider_off and en_steer inputs.
//
// The left and right load-cell readings are captured whenever ld_vld strobes.
// Their sum decides whether a rider is present, using a hysteresis band
// around MIN_RIDER_WT. Steering is granted only after the rider has stood
// balanced for a full dwell period, which is 2^26 clocks, or about 1.34 s at
// 50 MHz. Steering is withdrawn on gross imbalance or when the rider steps off.
//
// Ports
//   clk       in   1   system clock (50 MHz)
//   rst_n     in   1   asynchronous active-low reset
//   ld_vld    in   1   single-cycle strobe: lft_ld/rght_ld hold a fresh sample
//   lft_ld    in  12   left load cell, unsigned
//   rght_ld   in  12   right load cell, unsigned
//   rider_off out  1   registered, 1 = no rider on the platform
//   en_steer  out  1   registered, 1 = steering enabled
//
// Sample interface: there is no back-pressure. A sample is taken on every
// rising clock edge where ld_vld is 1. Between strobes the last captured pair
// is held, and every decision keeps using that held pair.
// -----------------------------------------------------------------------------
module steer_en #(
    parameter bit          fast_sim      = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [7:0]  WT_HYSTERESIS = 8'h40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        rider_off,
    output logic        en_steer
);

    // Edges of the rider-detect band. A sum lying exactly on either edge is
    // inside the band, so the previous decision is kept.
    localparam logic [12:0] RIDER_ON_TH  = {1'b0, MIN_RIDER_WT} + {5'd0, WT_HYSTERESIS};
    localparam logic [12:0] RIDER_OFF_TH = {1'b0, MIN_RIDER_WT} - {5'd0, WT_HYSTERESIS};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic        rider_off_q, rider_off_d;
    logic        en_steer_q, en_steer_d;
    logic [25:0] tmr_q, tmr_d;

    logic        clr_tmr;
    logic        tmr_full;
    logic [12:0] sum;
    logic [11:0] diff;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;

    // Load arithmetic, computed on the held samples. The 13-bit sum cannot
    // overflow. diff is the magnitude of the difference.
    always_comb begin
        sum           = {1'b0, lft_q} + {1'b0, rght_q};
        diff          = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
        // A diff exactly equal to a threshold does not count as exceeding it.
        diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
        diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));
    end

    // For simulation, the dwell ends when the low 15 bits of the timer roll to
    // all-ones, instead of the full 26 bits.
    assign tmr_full = fast_sim ? (&tmr_q[14:0]) : (&tmr_q);

    // Sample capture and rider hysteresis. rider_off is decided from the
    // registered samples, so it moves one clock after a new sample lands.
    always_comb begin
        lft_d       = ld_vld ? lft_ld  : lft_q;
        rght_d      = ld_vld ? rght_ld : rght_q;
        rider_off_d = rider_off_q;
        if (sum > RIDER_ON_TH) begin
            rider_off_d = 1'b0;
        end else if (sum < RIDER_OFF_TH) begin
            rider_off_d = 1'b1;
        end
    end

    // Next-state logic. Within each state the checks run in priority order:
    // rider_off first, then imbalance, then the dwell timer.
    always_comb begin
        state_d = state_q;
        clr_tmr = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rider_off_q) begin
                    state_d = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            WAIT: begin
                if (rider_off_q) begin
                    state_d = IDLE;
                end else if (diff_gt_1_4) begin
                    // Restart the dwell for as long as the rider is off balance.
                    clr_tmr = 1'b1;
                end else if (tmr_full) begin
                    state_d = STEER_EN;
                end
            end
            STEER_EN: begin
                if (rider_off_q) begin
                    state_d = IDLE;
                end else if (diff_gt_15_16) begin
                    state_d = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registering the decoded next state makes en_steer high exactly
        // while the FSM sits in STEER_EN.
        en_steer_d = (state_d == STEER_EN);
    end

    // Dwell timer: counts every clock and sticks at all-ones.
    always_comb begin
        if (clr_tmr) begin
            tmr_d = '0;
        end else if (&tmr_q) begin
            tmr_d = tmr_q;
        end else begin
            tmr_d = tmr_q + 26'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lft_q       <= '0;
            rght_q      <= '0;
            rider_off_q <= 1'b1;
            en_steer_q  <= 1'b0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            lft_q       <= lft_d;
            rght_q      <= rght_d;
            rider_off_q <= rider_off_d;
            en_steer_q  <= en_steer_d;
            tmr_q       <= tmr_d;
        end
    end

    assign rider_off = rider_off_q;
    assign en_steer  = en_steer_q;

endmodule
